stall_ctrl: RTL and testbench
=============================

Name: stall_ctrl

Overview:
- Consumer side of the hazard-detection stall interface. It takes the per-cause stall requests (`stall_J`, `stall_B`, `stall_RAW`) and turns them into concrete pipeline controls: PC write enable, IF/ID hold and flush, and ID/EX bubble.
- It arbitrates between the three causes and times the fixed-length stalls.
- It sits between the hazard detector and the PC / IF/ID / ID/EX pipeline registers.

Parameters:
- `B_STALL_CYCLES`, 3: cycles held in branch stall (branch resolves in stage 5). A value of 0 is treated as 1.
- `J_STALL_CYCLES`, 1: cycles held in jump flush. A value of 0 is treated as 1.
- `RAW_MAX_CYCLES`, 3: RAW watchdog limit. This is the maximum number of consecutive RAW stall cycles.
- `CNT_W`, 4: width of the internal down-counter. Must hold max(`B_STALL_CYCLES`, `J_STALL_CYCLES`, `RAW_MAX_CYCLES`).

Ports:
- `CLK` input 1: clock, rising edge.
- `RST` input 1: synchronous, active-high reset.
- `stall_J` input 1: jump-stall request.
- `stall_B` input 1: branch-stall request.
- `stall_RAW` input 1: data-hazard stall request.
- `PC_write` output 1: PC register load enable.
- `IFID_write` output 1: IF/ID register load enable.
- `IFID_flush` output 1: clears IF/ID to a NOP.
- `IDEX_bubble` output 1: forces ID/EX control fields to zero.
- `raw_timeout` output 1: one-cycle pulse when the RAW watchdog fires.
- `state_out` output 2: current state. IDLE=00, RAW=01, BR=10, JMP=11.

Behaviour:
- Decode style:
  - Moore FSM; the four pipeline-control outputs are decoded from the state register only.
  - Latency: a request sampled at posedge N drives the outputs from posedge N onward, i.e. they are valid in cycle N+1.
- Reset:
  - `RST` high at a posedge sets state=IDLE, counter=0 and `raw_timeout`=0.
  - Reset overrides any request sampled at the same edge. Reset in mid-stall aborts the stall immediately.
- Output decode per state:
  - IDLE: `PC_write`=1, `IFID_write`=1, `IFID_flush`=0, `IDEX_bubble`=0.
  - RAW: `PC_write`=0, `IFID_write`=0, `IFID_flush`=0, `IDEX_bubble`=1.
  - BR: `PC_write`=0, `IFID_write`=1, `IFID_flush`=1, `IDEX_bubble`=1.
  - JMP: `PC_write`=1 (the jump target loads), `IFID_write`=1, `IFID_flush`=1, `IDEX_bubble`=0.
- Transitions from IDLE (priority J > B > RAW):
  - `stall_J`: go to JMP, counter=`J_STALL_CYCLES`.
  - else `stall_B`: go to BR, counter=`B_STALL_CYCLES`.
  - else `stall_RAW`: go to RAW, counter=`RAW_MAX_CYCLES`.
  - else stay in IDLE.
- Transitions from RAW:
  - `stall_J` or `stall_B` preempts to JMP or BR (same priority, counter reloaded).
  - else `stall_RAW`=0: go to IDLE.
  - else counter==1: go to IDLE, `raw_timeout`=1 for exactly one cycle.
  - else decrement the counter.
- Transitions from BR:
  - Decrement each cycle; when counter==1, go to IDLE.
  - All requests are ignored while in BR; the counter is not reloaded.
  - The machine exits BR through IDLE, so a request still asserted after the exit is taken one cycle later.
- Transitions from JMP:
  - Same as BR, using the JMP count.
  - `stall_B` during JMP is ignored.
- Boundary cases:
  - Counter never underflows.
  - Parameters of 0 load as 1.
  - All requests asserted together from IDLE: JMP wins.
  - Back-to-back RAW stalls with a 1-cycle gap re-arm the watchdog.

Optional Feature:
- Macro: `STALL_CTRL_PERF_EN`.
- Defined:
  - Adds three 32-bit saturating output counters: `perf_raw_cycles`, `perf_br_cycles`, `perf_jmp_cycles`.
  - Each increments on every cycle spent in its state.
  - All three clear on `RST` and hold at 32'hFFFFFFFF.
- Undefined:
  - Ports and logic are absent.
  - All other behaviour is identical.

Test Plan:
- `RST`=1 for 2 cycles with all requests high. Required: state_out=00, `PC_write`=1, `IFID_write`=1, `IFID_flush`=0, `IDEX_bubble`=0, `raw_timeout`=0 after the edge.
- `stall_B` pulse 1 cycle from IDLE, defaults. Required: state_out=10 for exactly 3 cycles with `PC_write`=0 and `IFID_flush`=1, then IDLE.
- `stall_RAW` held 2 cycles. Required: RAW for 2 cycles with `PC_write`=0 and `IFID_write`=0, then IDLE; `raw_timeout` stays 0.
- `stall_RAW` held 10 cycles. Required: RAW for 3 cycles, `raw_timeout`=1 on the exit cycle, IDLE for 1 cycle, RAW re-entered.
- `stall_J`=`stall_B`=`stall_RAW`=1 in the same cycle from IDLE. Required: state_out=11 for 1 cycle with `PC_write`=1 and `IFID_flush`=1, then IDLE, then BR if `stall_B` is still high.
- `RST` asserted in the 2nd cycle of BR. Required: IDLE after that edge, counter cleared; with `STALL_CTRL_PERF_EN`, `perf_br_cycles`=0.

Source files
------------

// File: rtl/stall_ctrl.sv
// Stall controller: arbitrates jump/branch/RAW stall requests into PC, IF/ID and ID/EX controls.
// Optional STALL_CTRL_PERF_EN adds saturating per-state cycle counters.
module stall_ctrl #(
    parameter int B_STALL_CYCLES = 3,
    parameter int J_STALL_CYCLES = 1,
    parameter int RAW_MAX_CYCLES = 3,
    parameter int CNT_W          = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       stall_J,
    input  logic       stall_B,
    input  logic       stall_RAW,
    output logic       PC_write,
    output logic       IFID_write,
    output logic       IFID_flush,
    output logic       IDEX_bubble,
    output logic       raw_timeout,
    output logic [1:0] state_out
`ifdef STALL_CTRL_PERF_EN
    ,
    output logic [31:0] perf_raw_cycles,
    output logic [31:0] perf_br_cycles,
    output logic [31:0] perf_jmp_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RAW  = 2'b01,
        ST_BR   = 2'b10,
        ST_JMP  = 2'b11
    } state_t;

    // A zero-length stall would never leave its state, so zero loads as one.
    localparam logic [CNT_W-1:0] B_LOAD   = CNT_W'((B_STALL_CYCLES == 0) ? 1 : B_STALL_CYCLES);
    localparam logic [CNT_W-1:0] J_LOAD   = CNT_W'((J_STALL_CYCLES == 0) ? 1 : J_STALL_CYCLES);
    localparam logic [CNT_W-1:0] RAW_LOAD = CNT_W'((RAW_MAX_CYCLES == 0) ? 1 : RAW_MAX_CYCLES);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             raw_timeout_reg, raw_timeout_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg       <= ST_IDLE;
            cnt_reg         <= '0;
            raw_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cnt_reg         <= cnt_next;
            raw_timeout_reg <= raw_timeout_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        cnt_next         = cnt_reg;
        raw_timeout_next = 1'b0;
        case (state_reg)
            ST_IDLE, ST_RAW: begin
                if (stall_J) begin
                    state_next = ST_JMP;
                    cnt_next   = J_LOAD;
                end else if (stall_B) begin
                    state_next = ST_BR;
                    cnt_next   = B_LOAD;
                end else if (state_reg == ST_IDLE) begin
                    if (stall_RAW) begin
                        state_next = ST_RAW;
                        cnt_next   = RAW_LOAD;
                    end
                end else if (!stall_RAW) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg <= CNT_W'(1)) begin
                    // Watchdog expired: drop the stall and flag it for one cycle.
                    state_next       = ST_IDLE;
                    cnt_next         = '0;
                    raw_timeout_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_BR, ST_JMP: begin
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        PC_write    = 1'b1;
        IFID_write  = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        case (state_reg)
            ST_RAW: begin
                PC_write    = 1'b0;
                IFID_write  = 1'b0;
                IDEX_bubble = 1'b1;
            end
            ST_BR: begin
                PC_write    = 1'b0;
                IFID_flush  = 1'b1;
                IDEX_bubble = 1'b1;
            end
            ST_JMP: begin
                IFID_flush  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign raw_timeout = raw_timeout_reg;
    assign state_out   = state_reg;

`ifdef STALL_CTRL_PERF_EN
    // Counter gi tracks the state encoded as gi+1 (RAW, BR, JMP).
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
        localparam logic [1:0] MY_STATE = 2'(gi + 1);
        logic [31:0] cnt_perf_reg;
        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt_perf_reg <= '0;
            end else if (state_reg == MY_STATE && cnt_perf_reg != 32'hFFFF_FFFF) begin
                cnt_perf_reg <= cnt_perf_reg + 32'd1;
            end
        end
    end

    assign perf_raw_cycles = g_perf[0].cnt_perf_reg;
    assign perf_br_cycles  = g_perf[1].cnt_perf_reg;
    assign perf_jmp_cycles = g_perf[2].cnt_perf_reg;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed vector table, a hand-written reset-in-BR
// sequence, then random requests checked against a cycle-level behavioural model.
module tb_stall_ctrl;

    localparam int B_CYC   = 3;
    localparam int J_CYC   = 1;
    localparam int RAW_MAX = 3;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RAW  = 2'b01;
    localparam logic [1:0] S_BR   = 2'b10;
    localparam logic [1:0] S_JMP  = 2'b11;

    logic       CLK = 1'b0;
    logic       RST, stall_J, stall_B, stall_RAW;
    logic       PC_write, IFID_write, IFID_flush, IDEX_bubble, raw_timeout;
    logic [1:0] state_out;
`ifdef STALL_CTRL_PERF_EN
    logic [31:0] perf_raw_cycles, perf_br_cycles, perf_jmp_cycles;
`endif

    always #5 CLK = ~CLK;

    stall_ctrl #(
        .B_STALL_CYCLES(B_CYC),
        .J_STALL_CYCLES(J_CYC),
        .RAW_MAX_CYCLES(RAW_MAX),
        .CNT_W(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .stall_J(stall_J),
        .stall_B(stall_B),
        .stall_RAW(stall_RAW),
        .PC_write(PC_write),
        .IFID_write(IFID_write),
        .IFID_flush(IFID_flush),
        .IDEX_bubble(IDEX_bubble),
        .raw_timeout(raw_timeout),
        .state_out(state_out)
`ifdef STALL_CTRL_PERF_EN
        ,
        .perf_raw_cycles(perf_raw_cycles),
        .perf_br_cycles(perf_br_cycles),
        .perf_jmp_cycles(perf_jmp_cycles)
`endif
    );

    typedef struct {
        logic       rst;
        logic       j;
        logic       b;
        logic       raw;
        logic [1:0] st;
        logic       to;
    } vec_t;

    vec_t tab[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    // {PC_write, IFID_write, IFID_flush, IDEX_bubble} required in each state
    function automatic logic [3:0] ctrl_of(input logic [1:0] s);
        case (s)
            S_IDLE:  return 4'b1100;
            S_RAW:   return 4'b0001;
            S_BR:    return 4'b0111;
            default: return 4'b1110;
        endcase
    endfunction

    task automatic add(input logic r, input logic j, input logic b, input logic raw,
                       input logic [1:0] st, input logic to);
        vec_t v;
        v.rst = r; v.j = j; v.b = b; v.raw = raw; v.st = st; v.to = to;
        tab.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge happen, return at the following negedge.
    task automatic drive(input logic r, input logic j, input logic b, input logic raw);
        RST = r; stall_J = j; stall_B = b; stall_RAW = raw;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input int idx, input logic [1:0] est, input logic eto);
        logic [3:0] got_ctrl;
        got_ctrl = {PC_write, IFID_write, IFID_flush, IDEX_bubble};
        n_vec++;
        if (state_out !== est || got_ctrl !== ctrl_of(est) || raw_timeout !== eto) begin
            n_fail++;
            $display("FAIL %s[%0d]: got state=%b ctrl=%b timeout=%b, required state=%b ctrl=%b timeout=%b",
                     tag, idx, state_out, got_ctrl, raw_timeout, est, ctrl_of(est), eto);
        end
    endtask

    task automatic check_perf(input string tag, input int idx, input logic [31:0] got,
                              input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, required %0d", tag, idx, got, exp);
        end
    endtask

    // Behavioural model: mode plus "cycles left" for fixed stalls and "cycles spent" for RAW.
    logic [1:0] m_mode;
    int         m_left, m_raw_spent;
    logic       m_to;
    longint     m_perf[4];

    task automatic model_step(input logic r, input logic j, input logic b, input logic raw);
        logic [1:0] old_mode;
        old_mode = m_mode;
        m_to = 1'b0;
        if (r) begin
            m_mode = S_IDLE;
            for (int k = 0; k < 4; k++) m_perf[k] = 0;
            return;
        end
        if (old_mode != S_IDLE && m_perf[old_mode] < 64'hFFFF_FFFF) m_perf[old_mode]++;
        if ((old_mode == S_IDLE || old_mode == S_RAW) && j) begin
            m_mode = S_JMP; m_left = J_CYC;
        end else if ((old_mode == S_IDLE || old_mode == S_RAW) && b) begin
            m_mode = S_BR; m_left = B_CYC;
        end else if (old_mode == S_IDLE) begin
            if (raw) begin
                m_mode = S_RAW; m_raw_spent = 1;
            end
        end else if (old_mode == S_RAW) begin
            if (!raw) begin
                m_mode = S_IDLE;
            end else if (m_raw_spent >= RAW_MAX) begin
                m_mode = S_IDLE; m_to = 1'b1;
            end else begin
                m_raw_spent++;
            end
        end else begin
            m_left--;
            if (m_left <= 0) m_mode = S_IDLE;
        end
    endtask

    initial begin
        RST = 1'b1; stall_J = 1'b0; stall_B = 1'b0; stall_RAW = 1'b0;
        m_mode = S_IDLE; m_left = 0; m_raw_spent = 0; m_to = 1'b0;
        for (int k = 0; k < 4; k++) m_perf[k] = 0;

        // reset with every request high
        add(1,1,1,1, S_IDLE,0); add(1,1,1,1, S_IDLE,0);
        // branch pulse: three BR cycles then IDLE
        add(0,0,1,0, S_BR,0);   add(0,0,0,0, S_BR,0);   add(0,0,0,0, S_BR,0);
        add(0,0,0,0, S_IDLE,0); add(0,0,0,0, S_IDLE,0);
        // short RAW: released before the watchdog
        add(0,0,0,1, S_RAW,0);  add(0,0,0,1, S_RAW,0);  add(0,0,0,0, S_IDLE,0);
        // RAW held 10 cycles: watchdog fires, one IDLE cycle, re-arms
        add(0,0,0,1, S_RAW,0);  add(0,0,0,1, S_RAW,0);  add(0,0,0,1, S_RAW,0);
        add(0,0,0,1, S_IDLE,1); add(0,0,0,1, S_RAW,0);  add(0,0,0,1, S_RAW,0);
        add(0,0,0,1, S_RAW,0);  add(0,0,0,1, S_IDLE,1); add(0,0,0,1, S_RAW,0);
        add(0,0,0,1, S_RAW,0);  add(0,0,0,0, S_IDLE,0);
        // all requests together: JMP wins, B still high afterwards is taken via IDLE
        add(0,1,1,1, S_JMP,0);  add(0,0,1,0, S_IDLE,0); add(0,0,1,0, S_BR,0);
        add(0,0,0,0, S_BR,0);   add(0,0,0,0, S_BR,0);   add(0,0,0,0, S_IDLE,0);
        // RAW preempted by B, then by J
        add(0,0,0,1, S_RAW,0);  add(0,0,1,1, S_BR,0);   add(0,0,0,0, S_BR,0);
        add(0,0,0,0, S_BR,0);   add(0,0,0,0, S_IDLE,0);
        add(0,0,0,1, S_RAW,0);  add(0,1,0,1, S_JMP,0);  add(0,0,0,0, S_IDLE,0);
        // B during JMP ignored
        add(0,1,0,0, S_JMP,0);  add(0,0,1,0, S_IDLE,0); add(0,0,0,0, S_IDLE,0);

        foreach (tab[i]) begin
            drive(tab[i].rst, tab[i].j, tab[i].b, tab[i].raw);
            check("table", i, tab[i].st, tab[i].to);
        end

        // reset in the 2nd BR cycle aborts the stall and clears the counter
        drive(0,0,1,0); check("rst_br", 0, S_BR, 0);
        drive(0,0,0,0); check("rst_br", 1, S_BR, 0);
        drive(1,0,0,0); check("rst_br", 2, S_IDLE, 0);
`ifdef STALL_CTRL_PERF_EN
        check_perf("rst_br_perf", 2, perf_br_cycles, 32'd0);
`endif
        drive(0,0,0,0); check("rst_br", 3, S_IDLE, 0);
        // a fresh RAW gets the full watchdog window after the reset
        drive(0,0,0,1); check("rst_br", 4, S_RAW, 0);
        drive(0,0,0,1); check("rst_br", 5, S_RAW, 0);
        drive(0,0,0,1); check("rst_br", 6, S_RAW, 0);
        drive(0,0,0,1); check("rst_br", 7, S_IDLE, 1);

        // random phase against the model, starting from reset
        drive(1,0,0,0);
        model_step(1,0,0,0);
        check("rand", 0, m_mode, m_to);
        for (int i = 1; i < 600; i++) begin
            logic r, j, b, raw;
            r   = ($urandom_range(0, 39) == 0);
            j   = ($urandom_range(0, 9) == 0);
            b   = ($urandom_range(0, 7) == 0);
            raw = ($urandom_range(0, 3) != 0);
            drive(r, j, b, raw);
            model_step(r, j, b, raw);
            check("rand", i, m_mode, m_to);
`ifdef STALL_CTRL_PERF_EN
            check_perf("perf_raw", i, perf_raw_cycles, 32'(m_perf[S_RAW]));
            check_perf("perf_br",  i, perf_br_cycles,  32'(m_perf[S_BR]));
            check_perf("perf_jmp", i, perf_jmp_cycles, 32'(m_perf[S_JMP]));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
